// File: rtl/risc32_wb_arbiter_pkg.sv
// Shared constants and types for the write-back arbiter and its result queue.
package risc32_wb_arbiter_pkg;

    localparam int REG_W      = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    // Default long-latency queue depth and head-starvation limit.
    localparam int WBQ_DEPTH  = 4;
    localparam int WBQ_STARVE = 8;

    localparam logic [REG_W-1:0] WORD_ZERO = '0;

    // One queued long-latency result: destination register plus value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_W-1:0]      wdata;
    } wb_entry_t;

    localparam int ENTRY_W = $bits(wb_entry_t);

    // $0 is hard-wired to zero, so a write aimed there is never a real write.
    function automatic logic is_real_dest(input logic [REG_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/risc32_wb_fifo.sv
// Small synchronous FIFO holding long-latency results until the write port is free.
// The head is read combinationally so the arbiter can pop and write in one cycle.
module risc32_wb_fifo
    import risc32_wb_arbiter_pkg::*;
#(
    parameter int DEPTH = WBQ_DEPTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [ENTRY_W-1:0]     din,
    output logic [ENTRY_W-1:0]     dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic [PTR_W:0]     count_next;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr_reg];

    // Occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        count_next = count_reg;
        case ({do_push, do_pop})
            2'b10:   count_next = count_reg + (PTR_W+1)'(1);
            2'b01:   count_next = count_reg - (PTR_W+1)'(1);
            default: count_next = count_reg;
        endcase
    end

    // Storage write; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/risc32_wb_arbiter.sv
// Write-back arbiter: merges the in-order pipeline stream with queued
// long-latency results onto the single register-file write port, tracks
// registers still awaiting a long-latency write, and stalls the pipeline
// when the queue head has been starved for too long.
module risc32_wb_arbiter
    import risc32_wb_arbiter_pkg::*;
#(
    parameter int DEPTH        = WBQ_DEPTH,
    parameter int STARVE_LIMIT = WBQ_STARVE
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_we_i,
    input  logic [REG_ADDR_W-1:0] pipe_waddr_i,
    input  logic [REG_W-1:0]      pipe_wdata_i,
    input  logic                  lu_valid_i,
    output logic                  lu_ready_o,
    input  logic [REG_ADDR_W-1:0] lu_waddr_i,
    input  logic [REG_W-1:0]      lu_wdata_i,
    input  logic                  lu_issue_i,
    input  logic [REG_ADDR_W-1:0] lu_issue_addr_i,
    output logic [REG_NUM-1:0]    busy_o,
    output logic                  stall_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [REG_W-1:0]      wdata_o
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

    wb_entry_t             push_entry;
    wb_entry_t             head;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  push;
    logic                  pop;
    logic                  pipe_win;

    logic                  we_reg, we_next;
    logic [REG_ADDR_W-1:0] waddr_reg, waddr_next;
    logic [REG_W-1:0]      wdata_reg, wdata_next;
    logic [STARVE_W-1:0]   starve_reg, starve_next;
    logic                  stall_reg, stall_next;
    logic [REG_NUM-1:0]    busy_reg, busy_next;

    assign push_entry = '{waddr: lu_waddr_i, wdata: lu_wdata_i};

    // Ready uses the pre-edge count, so a full queue refuses even when it pops this cycle.
    assign lu_ready_o = (fifo_count != CNT_W'(DEPTH)) && !rst;
    assign push       = lu_valid_i && !fifo_full && !rst;

    // A pipe write to $0 is no request; otherwise the pipe always wins the port.
    assign pipe_win = pipe_we_i && is_real_dest(pipe_waddr_i);
    assign pop      = !pipe_win && !fifo_empty;

    risc32_wb_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_entry),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Port selection: pipe first, then queue head; a $0 head is drained without a write.
    always_comb begin
        we_next    = 1'b0;
        waddr_next = '0;
        wdata_next = WORD_ZERO;
        if (pipe_win) begin
            we_next    = 1'b1;
            waddr_next = pipe_waddr_i;
            wdata_next = pipe_wdata_i;
        end else if (pop && is_real_dest(head.waddr)) begin
            we_next    = 1'b1;
            waddr_next = head.waddr;
            wdata_next = head.wdata;
        end
    end

    // Starvation: count cycles the head waits, saturating at the limit that raises stall.
    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_reg != STARVE_W'(STARVE_LIMIT)) begin
            starve_next = starve_reg + STARVE_W'(1);
        end
        stall_next = (starve_next == STARVE_W'(STARVE_LIMIT));
    end

    // Scoreboard: an issue sets a bit and beats a same-cycle clear by a queue pop; $0 never busy.
    assign busy_next[0] = 1'b0;
    genvar gi;
    generate
        for (gi = 1; gi < REG_NUM; gi++) begin : g_busy
            assign busy_next[gi] =
                (lu_issue_i && (lu_issue_addr_i == REG_ADDR_W'(gi))) ? 1'b1 :
                (pop && (head.waddr == REG_ADDR_W'(gi)))             ? 1'b0 :
                                                                       busy_reg[gi];
        end
    endgenerate

    // State registers; reset drops the write, the stall and every pending bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_reg     <= 1'b0;
            waddr_reg  <= '0;
            wdata_reg  <= WORD_ZERO;
            starve_reg <= '0;
            stall_reg  <= 1'b0;
            busy_reg   <= '0;
        end else begin
            we_reg     <= we_next;
            waddr_reg  <= waddr_next;
            wdata_reg  <= wdata_next;
            starve_reg <= starve_next;
            stall_reg  <= stall_next;
            busy_reg   <= busy_next;
        end
    end

    assign we_o    = we_reg;
    assign waddr_o = waddr_reg;
    assign wdata_o = wdata_reg;
    assign stall_o = stall_reg;
    assign busy_o  = busy_reg;

endmodule

// File: tb/tb_risc32_wb_arbiter.sv
// Bench for the write-back arbiter: directed scenarios plus a randomized run
// against a queue-based reference model of the write-port rules.
module tb_risc32_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;

    logic        clk;
    logic        rst;
    logic        pipe_we_i;
    logic [4:0]  pipe_waddr_i;
    logic [31:0] pipe_wdata_i;
    logic        lu_valid_i;
    logic        lu_ready_o;
    logic [4:0]  lu_waddr_i;
    logic [31:0] lu_wdata_i;
    logic        lu_issue_i;
    logic [4:0]  lu_issue_addr_i;
    logic [31:0] busy_o;
    logic        stall_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int checks   = 0;
    int failures = 0;

    risc32_wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .pipe_we_i       (pipe_we_i),
        .pipe_waddr_i    (pipe_waddr_i),
        .pipe_wdata_i    (pipe_wdata_i),
        .lu_valid_i      (lu_valid_i),
        .lu_ready_o      (lu_ready_o),
        .lu_waddr_i      (lu_waddr_i),
        .lu_wdata_i      (lu_wdata_i),
        .lu_issue_i      (lu_issue_i),
        .lu_issue_addr_i (lu_issue_addr_i),
        .busy_o          (busy_o),
        .stall_o         (stall_o),
        .we_o            (we_o),
        .waddr_o         (waddr_o),
        .wdata_o         (wdata_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_busy;
    int          m_starve;
    logic        m_stall;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_edge();
        int          pre_size;
        logic [31:0] clr;
        logic [31:0] set;
        ent_t        h;
        if (rst) begin
            mq.delete();
            m_busy = '0; m_starve = 0; m_stall = 1'b0;
            m_we = 1'b0; m_waddr = '0; m_wdata = '0;
            return;
        end
        pre_size = mq.size();
        clr = '0;
        set = '0;
        m_we = 1'b0; m_waddr = '0; m_wdata = '0;
        if (pipe_we_i && pipe_waddr_i != 5'd0) begin
            m_we = 1'b1; m_waddr = pipe_waddr_i; m_wdata = pipe_wdata_i;
            if (pre_size == 0) m_starve = 0;
            else if (m_starve < LIMIT) m_starve = m_starve + 1;
        end else if (pre_size > 0) begin
            h = mq.pop_front();
            if (h.a != 5'd0) begin
                m_we = 1'b1; m_waddr = h.a; m_wdata = h.d;
            end
            clr[h.a] = 1'b1;
            m_starve = 0;
        end else begin
            m_starve = 0;
        end
        if (lu_valid_i && pre_size < DEPTH) mq.push_back({lu_waddr_i, lu_wdata_i});
        if (lu_issue_i && lu_issue_addr_i != 5'd0) set[lu_issue_addr_i] = 1'b1;
        m_busy  = (m_busy & ~clr) | set;
        m_stall = (m_starve >= LIMIT);
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL reset_we: got %b want 0", we_o); end
        checks++; if (waddr_o !== 5'd0) begin failures++; $display("FAIL reset_waddr: got %0d want 0", waddr_o); end
        checks++; if (wdata_o !== 32'd0) begin failures++; $display("FAIL reset_wdata: got %h want 0", wdata_o); end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        checks++; if (busy_o !== 32'd0) begin failures++; $display("FAIL reset_busy: got %h want 0", busy_o); end
        checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b want 0", lu_ready_o); end
        rst = 1'b0;
        #1;
        checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL ready_after_reset: got %b want 1", lu_ready_o); end
        $display("test_reset done");
    endtask

    task automatic test_pipe_only();
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd5; pipe_wdata_i = 32'h0000_1234;
        tick();
        pipe_we_i = 1'b0;
        checks++; if (we_o !== 1'b1 || waddr_o !== 5'd5 || wdata_o !== 32'h0000_1234) begin
            failures++; $display("FAIL pipe_write: got we=%b r%0d=%h want we=1 r5=00001234", we_o, waddr_o, wdata_o);
        end
        $display("pipe write r%0d <= %08h", waddr_o, wdata_o);
        tick();
        checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL pipe_idle: got we=%b want 0", we_o); end
    endtask

    task automatic test_lu_path();
        lu_issue_i = 1'b1; lu_issue_addr_i = 5'd7;
        tick();
        lu_issue_i = 1'b0;
        checks++; if (busy_o[7] !== 1'b1) begin failures++; $display("FAIL issue_busy: got busy[7]=%b want 1", busy_o[7]); end
        lu_valid_i = 1'b1; lu_waddr_i = 5'd7; lu_wdata_i = 32'hDEAD_BEEF;
        #1;
        checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL lu_ready_empty: got %b want 1", lu_ready_o); end
        tick();
        lu_valid_i = 1'b0;
        checks++; if (we_o !== 1'b0 || busy_o[7] !== 1'b1) begin
            failures++; $display("FAIL no_fallthrough: got we=%b busy[7]=%b want we=0 busy[7]=1", we_o, busy_o[7]);
        end
        tick();
        checks++; if (we_o !== 1'b1 || waddr_o !== 5'd7 || wdata_o !== 32'hDEAD_BEEF) begin
            failures++; $display("FAIL lu_write: got we=%b r%0d=%h want we=1 r7=deadbeef", we_o, waddr_o, wdata_o);
        end
        checks++; if (busy_o[7] !== 1'b0) begin failures++; $display("FAIL busy_clear: got busy[7]=%b want 0", busy_o[7]); end
        $display("lu write r%0d <= %08h", waddr_o, wdata_o);
    endtask

    task automatic test_fifo_full();
        logic [4:0]  ea[5];
        logic [31:0] ed[5];
        int          n_seen;
        logic        accepted;
        for (int i = 0; i < 5; i++) begin
            ea[i] = 5'(11 + i);
            ed[i] = $urandom;
        end
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd1;
        for (int i = 0; i < 4; i++) begin
            pipe_wdata_i = $urandom;
            lu_valid_i = 1'b1; lu_waddr_i = ea[i]; lu_wdata_i = ed[i];
            #1;
            checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL fill_ready%0d: got %b want 1", i, lu_ready_o); end
            tick();
            checks++; if (we_o !== 1'b1 || waddr_o !== 5'd1) begin
                failures++; $display("FAIL pipe_priority%0d: got we=%b r%0d want we=1 r1", i, we_o, waddr_o);
            end
        end
        lu_waddr_i = ea[4]; lu_wdata_i = ed[4];
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL full_ready%0d: got %b want 0", c, lu_ready_o); end
            tick();
        end
        pipe_we_i = 1'b0;
        n_seen = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            accepted = lu_valid_i && lu_ready_o;
            tick();
            if (accepted) lu_valid_i = 1'b0;
            if (we_o === 1'b1) begin
                $display("drain write r%0d <= %08h", waddr_o, wdata_o);
                if (n_seen < 5) begin
                    checks++; if (waddr_o !== ea[n_seen] || wdata_o !== ed[n_seen]) begin
                        failures++; $display("FAIL drain_order%0d: got r%0d=%h want r%0d=%h", n_seen, waddr_o, wdata_o, ea[n_seen], ed[n_seen]);
                    end
                end
                n_seen++;
            end
        end
        checks++; if (n_seen != 5) begin failures++; $display("FAIL drain_count: got %0d writes want 5", n_seen); end
        lu_valid_i = 1'b0;
    endtask

    task automatic test_starve();
        logic [31:0] d;
        d = $urandom;
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd2; pipe_wdata_i = $urandom;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd3; lu_wdata_i = d;
        tick();
        lu_valid_i = 1'b0;
        for (int k = 1; k <= LIMIT; k++) begin
            pipe_wdata_i = $urandom;
            tick();
            checks++; if (stall_o !== (k >= LIMIT)) begin
                failures++; $display("FAIL starve_k%0d: got stall=%b want %b", k, stall_o, (k >= LIMIT));
            end
        end
        pipe_we_i = 1'b0;
        tick();
        checks++; if (we_o !== 1'b1 || waddr_o !== 5'd3 || wdata_o !== d) begin
            failures++; $display("FAIL starve_pop: got we=%b r%0d=%h want we=1 r3=%h", we_o, waddr_o, wdata_o, d);
        end
        checks++; if (stall_o !== 1'b0) begin failures++; $display("FAIL stall_drop: got %b want 0", stall_o); end
        $display("starved write r%0d <= %08h", waddr_o, wdata_o);
    endtask

    task automatic test_zero_dest();
        logic [31:0] d;
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd0; pipe_wdata_i = $urandom;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd0; lu_wdata_i = $urandom;
        tick();
        lu_valid_i = 1'b0;
        checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL zero_pipe: got we=%b want 0", we_o); end
        tick();
        checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL zero_head: got we=%b want 0", we_o); end
        d = $urandom;
        pipe_we_i = 1'b0;
        lu_valid_i = 1'b1; lu_waddr_i = 5'd9; lu_wdata_i = d;
        tick();
        lu_valid_i = 1'b0;
        checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL zero_gap: got we=%b want 0", we_o); end
        tick();
        checks++; if (we_o !== 1'b1 || waddr_o !== 5'd9 || wdata_o !== d) begin
            failures++; $display("FAIL zero_consumed: got we=%b r%0d=%h want we=1 r9=%h", we_o, waddr_o, wdata_o, d);
        end
        $display("after zero-dest write r%0d <= %08h", waddr_o, wdata_o);
    endtask

    task automatic test_reset_mid();
        pipe_we_i = 1'b1; pipe_waddr_i = 5'd4;
        for (int i = 0; i < 3; i++) begin
            pipe_wdata_i = $urandom;
            lu_issue_i = 1'b1; lu_issue_addr_i = 5'(20 + i);
            lu_valid_i = 1'b1; lu_waddr_i = 5'(20 + i); lu_wdata_i = $urandom;
            tick();
        end
        lu_issue_i = 1'b0; lu_valid_i = 1'b0;
        checks++; if (busy_o !== 32'h0070_0000) begin failures++; $display("FAIL mid_busy: got %h want 00700000", busy_o); end
        rst = 1'b1; pipe_we_i = 1'b0;
        #1;
        checks++; if (lu_ready_o !== 1'b0) begin failures++; $display("FAIL mid_rst_ready: got %b want 0", lu_ready_o); end
        tick();
        rst = 1'b0;
        checks++; if (busy_o !== 32'd0 || we_o !== 1'b0 || stall_o !== 1'b0) begin
            failures++; $display("FAIL mid_rst_state: got busy=%h we=%b stall=%b want 0/0/0", busy_o, we_o, stall_o);
        end
        for (int c = 0; c < 6; c++) begin
            tick();
            checks++; if (we_o !== 1'b0) begin failures++; $display("FAIL stale_write%0d: got we=%b r%0d", c, we_o, waddr_o); end
        end
        #1;
        checks++; if (lu_ready_o !== 1'b1) begin failures++; $display("FAIL mid_ready: got %b want 1", lu_ready_o); end
        $display("test_reset_mid done");
    endtask

    task automatic test_random(input int n);
        logic [4:0] a;
        for (int c = 0; c < n; c++) begin
            rst          = ($urandom_range(0, 299) == 0);
            pipe_we_i    = m_stall ? 1'b0 : 1'($urandom_range(0, 1));
            pipe_waddr_i = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
            pipe_wdata_i = $urandom;
            lu_valid_i   = ($urandom_range(0, 9) < 4);
            lu_waddr_i   = 5'($urandom_range(0, 31));
            lu_wdata_i   = $urandom;
            a            = 5'($urandom_range(1, 31));
            lu_issue_i   = ($urandom_range(0, 9) < 3) && !m_busy[a];
            lu_issue_addr_i = a;
            #1;
            checks++; if (lu_ready_o !== (!rst && mq.size() < DEPTH)) begin
                failures++; $display("FAIL rnd_ready c%0d: got %b want %b", c, lu_ready_o, (!rst && mq.size() < DEPTH));
            end
            tick();
            checks++; if (we_o !== m_we) begin failures++; $display("FAIL rnd_we c%0d: got %b want %b", c, we_o, m_we); end
            if (m_we) begin
                checks++; if (waddr_o !== m_waddr || wdata_o !== m_wdata) begin
                    failures++; $display("FAIL rnd_data c%0d: got r%0d=%h want r%0d=%h", c, waddr_o, wdata_o, m_waddr, m_wdata);
                end
                $display("[%0t] wb r%0d <= %08h", $time, waddr_o, wdata_o);
            end
            checks++; if (busy_o !== m_busy) begin failures++; $display("FAIL rnd_busy c%0d: got %h want %h", c, busy_o, m_busy); end
            checks++; if (stall_o !== m_stall) begin failures++; $display("FAIL rnd_stall c%0d: got %b want %b", c, stall_o, m_stall); end
        end
        rst = 1'b0;
        pipe_we_i = 1'b0; lu_valid_i = 1'b0; lu_issue_i = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        pipe_we_i = 1'b0; pipe_waddr_i = '0; pipe_wdata_i = '0;
        lu_valid_i = 1'b0; lu_waddr_i = '0; lu_wdata_i = '0;
        lu_issue_i = 1'b0; lu_issue_addr_i = '0;
        test_reset();
        test_pipe_only();
        test_lu_path();
        test_fifo_full();
        test_starve();
        test_zero_dest();
        test_reset_mid();
        test_random(3000);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
